adder_arbiter: RTL and testbench
================================

# adder_arbiter

Round-robin arbiter sharing one 32-bit ripple-carry adder between N requesters. Each requester offers operands over a valid/ready handshake. The winner's operands pass through the shared `fulladder` chain, and the result goes into a single registered response slot tagged with the requester index. A lock/chain option lets one requester hold the adder across consecutive words, forwarding carry between them for multi-word adds.

## Interface
- `N`, default 4: number of requesters, 2..8.
- `W`, default 32: operand width; adder width is fixed equal to `W`.
- `IDW`, default `$clog2(N)`: response tag width.
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `req_valid`, in, N: requester i has operands.
- `req_ready`, out, N: one-hot grant; transfer on `req_valid[i] & req_ready[i]`.
- `req_a`, in, N*W: operand A of requester i in bits `[i*W +: W]`.
- `req_b`, in, N*W: operand B, same packing.
- `req_cin`, in, N: carry-in of requester i (used when not chaining).
- `req_lock`, in, N: hold the grant for the next transaction of requester i.
- `req_chain`, in, N: use the stored carry-out of the previous word as carry-in.
- `rsp_valid`, out, 1: result slot occupied.
- `rsp_ready`, in, 1: consumer accepts the result.
- `rsp_sum`, out, W: A+B+cin, modulo 2^W.
- `rsp_cout`, out, 1: carry-out of bit W-1.
- `rsp_id`, out, IDW: index of the requester that produced the result.

## Operation
- **Slot free:** `slot_free = !rsp_valid | rsp_ready`.
- **Grant rules:**
  - `req_ready` is asserted only when `slot_free` is 1, and never during `reset`.
  - When locked, the grant goes only to `lock_owner`, and only if its `req_valid` is high.
  - When unlocked, the grant goes to the first valid requester scanning `ptr`, `ptr+1`, … mod N.
- **On a transfer from requester g:**
  - Adder inputs are `req_a[g]`, `req_b[g]`, and cin. cin is `carry_q` if `req_chain[g]` and `locked` were both set; otherwise cin is `req_cin[g]`.
  - The slot loads `sum`, `cout`, and `id=g`, and `rsp_valid` goes to 1.
  - `carry_q` loads cout.
  - If `req_lock[g]`: `locked=1`, `lock_owner=g`, and `ptr` is unchanged.
  - Else: `locked=0`, and `ptr = (g+1) mod N`.
- **No transfer:** if `rsp_ready & rsp_valid` without a new transfer, `rsp_valid` goes to 0. Slot data is unchanged.
- **Chain outside a lock:** `req_chain` is ignored when not locked; the first word of a chain always uses `req_cin`.
- **Locked, owner idle:** while locked, an owner with `req_valid=0` stalls the arbiter. No other requester is granted; this is the intended behaviour.
- **Arbiter state:**
  - UNLOCKED: a transfer with `req_lock` moves to LOCKED; a transfer without it stays UNLOCKED.
  - LOCKED: a transfer without `req_lock` returns to UNLOCKED; a transfer with it stays LOCKED.

## Timing
- **Reset values (one cycle of `reset`):**
  - `rsp_valid=0`, `rsp_sum=0`, `rsp_cout=0`, `rsp_id=0`.
  - `ptr=0`, `locked=0`, `lock_owner=0`, `carry_q=0`.
  - `req_ready` is all 0 while `reset` is high.
- **Latency:** 1 cycle. A transfer in cycle t gives `rsp_valid` and data in t+1.
- **Throughput:** 1 result per cycle while `rsp_ready` is held high.
- **Simultaneous events:** consume and refill in the same cycle is allowed. The slot is overwritten and `rsp_valid` stays 1.
- **Backpressure:** with `rsp_valid=1` and `rsp_ready=0`, `req_ready` is 0. `rsp_*` stay stable until accepted.
- **Combinational paths:**
  - `req_ready` depends combinationally on `rsp_ready`, `req_valid`, and state.
  - `req_ready` has no path from `req_a`, `req_b`, or `req_cin`.
- **Adder path:** a full W-bit ripple path, single cycle; no multicycle constraint.
- **Reset mid-operation:** any in-flight result and any lock are discarded. The next grant starts from requester 0.

## Structure
- **Shared package `adder_pkg`:**
  - Constant `ADDER_W=32`.
  - Function `rr_pick(valid, ptr)` returning the one-hot grant.
  - Typedef `rsp_t` holding `{sum, cout, id}`.
- **Sub-module:** exactly one, the existing 32-bit ripple-carry adder (the `fulladder` chain). It is instantiated once as the shared datapath and stays combinational.
- **Arbiter logic:** grant logic, lock FSM, `carry_q`, and the response register live in `adder_arbiter`.

## Test plan
- **Single requester:** N=4, only req 2 valid, A=5, B=7, cin=1 → next cycle `rsp_sum=13`, `rsp_cout=0`, `rsp_id=2`.
- **Round robin:** all 4 valid every cycle, `rsp_ready=1` → grants 0,1,2,3,0 on consecutive cycles; `rsp_id` follows one cycle later.
- **Wrap and backpressure:** A=FFFF_FFFF, B=1, cin=0 with `rsp_ready=0` for 3 cycles → `rsp_sum=0`, `rsp_cout=1` held stable, `req_ready=0` throughout.
- **64-bit chained add:** req 1 issues low word FFFF_FFFF+1 with lock=1. Reqs 0 and 3 valid meanwhile are not granted. Req 1 then issues high word 0+0 with chain=1, lock=0 → second `rsp_sum=1`. Next grant goes to req 3 (ptr=2 → first valid).
- **Reset mid-operation:** assert `reset` while locked with `rsp_valid=1` → next cycle `rsp_valid=0`, all `req_ready=0`. After release, first grant goes to the lowest valid index.

Source files
------------

// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : adder_pkg
//  Purpose  : Shared types, constants and the round-robin pick helper for the
//             adder_arbiter block.
//  Contents : ADDER_W      - width of the shared ripple-carry adder
//             MAX_N        - largest supported requester count
//             MAX_IDW      - tag width covering MAX_N requesters
//             arb_state_t  - lock FSM state encoding
//             rsp_t        - response slot contents {sum, cout, id}
//             rr_pick()    - one-hot round-robin grant from a rotation pointer
//  Revision : 1.0 - initial release
// ============================================================================
package adder_pkg;

    localparam int ADDER_W = 32;
    localparam int MAX_N   = 8;
    localparam int MAX_IDW = 3;

    typedef enum logic [0:0] {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [ADDER_W-1:0] sum;
        logic               cout;
        logic [MAX_IDW-1:0] id;
    } rsp_t;

    // Scan ptr, ptr+1, ... (mod n) and grant the first valid requester.
    // Vectors are sized for MAX_N; callers zero-extend and truncate.
    function automatic logic [MAX_N-1:0] rr_pick(
        input logic [MAX_N-1:0]   valid,
        input logic [MAX_IDW-1:0] ptr,
        input int unsigned        n
    );
        logic [MAX_N-1:0]   grant;
        logic               found;
        int unsigned        idx;
        logic [MAX_IDW-1:0] idx_s;
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            if (i < n && !found) begin
                idx   = (32'(ptr) + i) % n;
                idx_s = MAX_IDW'(idx);
                if (valid[idx_s]) begin
                    grant[idx_s] = 1'b1;
                    found        = 1'b1;
                end
            end
        end
        return grant;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fulladder.sv
`default_nettype none
// ============================================================================
//  Module   : fulladder
//  Purpose  : W-bit ripple-carry adder built as a chain of full-adder cells.
//             Purely combinational; shared datapath of adder_arbiter.
//  Ports    : a, b  [W-1:0] in  - operands
//             cin          in  - carry into bit 0
//             sum   [W-1:0] out - a + b + cin modulo 2^W
//             cout         out - carry out of bit W-1
//  Revision : 1.0 - initial release
// ============================================================================
module fulladder
    import adder_pkg::*;
#(
    parameter int W = ADDER_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] w_carry;

    assign w_carry[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
        assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
    end

    assign cout = w_carry[W];

endmodule
`default_nettype wire

// File: rtl/adder_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : adder_arbiter
//  Purpose  : Round-robin arbiter sharing one ripple-carry adder among N
//             requesters. A requester may lock the adder across consecutive
//             words and chain the stored carry for multi-word additions.
//             Results land in a single registered slot tagged with the
//             requester index.
//  Ports    : clk, reset                 - clock, synchronous active-high reset
//             req_valid/req_ready [N]    - per-requester handshake (one-hot grant)
//             req_a/req_b [N*W]          - operands, requester i at [i*W +: W]
//             req_cin/lock/chain [N]     - carry-in, hold grant, use stored carry
//             rsp_valid/rsp_ready        - response slot handshake
//             rsp_sum [W], rsp_cout,     - result, carry-out,
//             rsp_id [IDW]                 producing requester
//  Revision : 1.0 - initial release
// ============================================================================
module adder_arbiter
    import adder_pkg::*;
#(
    parameter int N   = 4,
    parameter int W   = ADDER_W,
    parameter int IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req_valid,
    output logic [N-1:0]   req_ready,
    input  logic [N*W-1:0] req_a,
    input  logic [N*W-1:0] req_b,
    input  logic [N-1:0]   req_cin,
    input  logic [N-1:0]   req_lock,
    input  logic [N-1:0]   req_chain,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [W-1:0]   rsp_sum,
    output logic           rsp_cout,
    output logic [IDW-1:0] rsp_id
);

    arb_state_t     r_state;
    arb_state_t     w_state_nxt;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] r_owner;
    logic           r_carry;
    rsp_t           r_rsp;
    logic           r_rsp_valid;

    logic             w_slot_free;
    logic [MAX_N-1:0] w_valid_ext;
    logic [N-1:0]     w_rr_gnt;
    logic [N-1:0]     w_lock_gnt;
    logic [N-1:0]     w_gnt;
    logic             w_xfer;
    logic [IDW-1:0]   w_gidx;
    logic [IDW-1:0]   w_ptr_nxt;
    logic [W-1:0]     w_a;
    logic [W-1:0]     w_b;
    logic             w_cin;
    logic [W-1:0]     w_sum;
    logic             w_cout;

    assign w_slot_free = !r_rsp_valid || rsp_ready;

    always_comb begin
        w_valid_ext        = '0;
        w_valid_ext[N-1:0] = req_valid;
    end

    assign w_rr_gnt = N'(rr_pick(w_valid_ext, MAX_IDW'(r_ptr), N));

    // While locked only the owner may be granted; an idle owner stalls
    // everyone else on purpose so a multi-word add is never interleaved.
    always_comb begin
        w_lock_gnt          = '0;
        w_lock_gnt[r_owner] = req_valid[r_owner];
    end

    // Grant selection and lock FSM next state.
    always_comb begin
        w_gnt       = '0;
        w_state_nxt = r_state;
        w_gidx      = '0;
        if (!reset && w_slot_free) begin
            w_gnt = (r_state == ST_LOCKED) ? w_lock_gnt : w_rr_gnt;
        end
        w_xfer = |(w_gnt & req_valid);
        for (int i = 0; i < N; i++) begin
            if (w_gnt[i]) begin
                w_gidx = IDW'(i);
            end
        end
        if (w_xfer) begin
            w_state_nxt = req_lock[w_gidx] ? ST_LOCKED : ST_UNLOCKED;
        end
    end

    assign req_ready = w_gnt;

    // Operand mux into the shared adder; chain only honoured inside a lock.
    assign w_a   = req_a[w_gidx*W +: W];
    assign w_b   = req_b[w_gidx*W +: W];
    assign w_cin = (r_state == ST_LOCKED && req_chain[w_gidx]) ? r_carry
                                                               : req_cin[w_gidx];

    assign w_ptr_nxt = (w_gidx == IDW'(N-1)) ? '0 : w_gidx + IDW'(1);

    fulladder #(
        .W (W)
    ) u_adder (
        .a    (w_a),
        .b    (w_b),
        .cin  (w_cin),
        .sum  (w_sum),
        .cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_UNLOCKED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr       <= '0;
            r_owner     <= '0;
            r_carry     <= 1'b0;
            r_rsp       <= '0;
            r_rsp_valid <= 1'b0;
        end else if (w_xfer) begin
            r_rsp.sum   <= ADDER_W'(w_sum);
            r_rsp.cout  <= w_cout;
            r_rsp.id    <= MAX_IDW'(w_gidx);
            r_rsp_valid <= 1'b1;
            r_carry     <= w_cout;
            if (req_lock[w_gidx]) begin
                r_owner <= w_gidx;
            end else begin
                r_ptr   <= w_ptr_nxt;
            end
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_sum   = W'(r_rsp.sum);
    assign rsp_cout  = r_rsp.cout;
    assign rsp_id    = IDW'(r_rsp.id);

endmodule
`default_nettype wire

// File: tb/tb_adder_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adder_arbiter
//  Purpose  : Directed self-checking bench for adder_arbiter (N=4, W=32).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adder_arbiter;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int IDW = 2;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_cin;
    logic [N-1:0]   req_lock;
    logic [N-1:0]   req_chain;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_sum;
    logic           rsp_cout;
    logic [IDW-1:0] rsp_id;

    int n_vec;
    int n_err;

    adder_arbiter #(
        .N   (N),
        .W   (W),
        .IDW (IDW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_lock  (req_lock),
        .req_chain (req_chain),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic lock, input logic chain);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_cin[i]      = cin;
        req_lock[i]     = lock;
        req_chain[i]    = chain;
    endtask

    task automatic check_rsp(input string tag, input logic v, input logic [W-1:0] s,
                             input logic c, input logic [IDW-1:0] id);
        check({tag, ".valid"}, 64'(rsp_valid), 64'(v));
        check({tag, ".sum"},   64'(rsp_sum),   64'(s));
        check({tag, ".cout"},  64'(rsp_cout),  64'(c));
        check({tag, ".id"},    64'(rsp_id),    64'(id));
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        reset     = 1'b1;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        req_lock  = '0;
        req_chain = '0;
        rsp_ready = 1'b0;
        #1;
        check("ready_in_reset", 64'(req_ready), 64'(0));
        tick();
        check_rsp("reset", 1'b0, 32'd0, 1'b0, 2'd0);
        check("ready_in_reset2", 64'(req_ready), 64'(0));

        // Single requester: only req 2 valid, 5 + 7 + 1.
        reset     = 1'b0;
        req_valid = 4'b0100;
        set_req(2, 32'd5, 32'd7, 1'b1, 1'b0, 1'b0);
        #1;
        check("single.ready", 64'(req_ready), 64'(4'b0100));
        tick();
        req_valid = '0;
        check_rsp("single", 1'b1, 32'd13, 1'b0, 2'd2);
        rsp_ready = 1'b1;
        tick();
        check("drain.valid", 64'(rsp_valid), 64'(0));

        // Round robin from a fresh pointer: grants 0,1,2,3,0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 32'(i * 10), 32'd1, 1'b0, 1'b0, 1'b0);
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("rr.ready", 64'(req_ready), 64'(4'b0001 << (k % 4)));
            tick();
            check_rsp("rr", 1'b1, 32'((k % 4) * 10 + 1), 1'b0, 2'(k % 4));
        end

        // Wrap with backpressure: req 1 FFFF_FFFF + 1 -> 0, cout 1, held.
        req_valid = 4'b0010;
        set_req(1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0);
        #1;
        check("wrap.ready", 64'(req_ready), 64'(4'b0010));
        tick();
        rsp_ready = 1'b0;
        set_req(1, 32'h1234_5678, 32'd9, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp.ready", 64'(req_ready), 64'(0));
            check_rsp("bp", 1'b1, 32'd0, 1'b1, 2'd1);
            tick();
        end
        check_rsp("bp.after", 1'b1, 32'd0, 1'b1, 2'd1);

        // Chain outside a lock is ignored: 1 + 1 + cin0 = 2 even with carry_q=1.
        rsp_ready = 1'b1;
        req_valid = 4'b0100;
        set_req(2, 32'd1, 32'd1, 1'b0, 1'b0, 1'b1);
        #1;
        check("nolock_chain.ready", 64'(req_ready), 64'(4'b0100));
        tick();
        check_rsp("nolock_chain", 1'b1, 32'd2, 1'b0, 2'd2);

        // 64-bit chained add by req 1 with 0 and 3 contending.
        req_valid = 4'b0010;
        set_req(1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 1'b0);
        set_req(2, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        #1;
        check("lo.ready", 64'(req_ready), 64'(4'b0010));
        tick();
        check_rsp("lo", 1'b1, 32'd0, 1'b1, 2'd1);
        req_valid = 4'b1001;
        #1;
        check("stall.ready", 64'(req_ready), 64'(0));
        tick();
        check("stall.valid", 64'(rsp_valid), 64'(0));
        req_valid = 4'b1011;
        set_req(1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        #1;
        check("hi.ready", 64'(req_ready), 64'(4'b0010));
        tick();
        check_rsp("hi", 1'b1, 32'd1, 1'b0, 2'd1);
        req_valid = 4'b1001;
        #1;
        check("after_unlock.ready", 64'(req_ready), 64'(4'b1000));
        tick();
        check("after_unlock.id", 64'(rsp_id), 64'(3));

        // Reset mid-operation while locked with a pending result.
        req_valid = 4'b0100;
        set_req(2, 32'd3, 32'd4, 1'b0, 1'b1, 1'b0);
        #1;
        check("lock2.ready", 64'(req_ready), 64'(4'b0100));
        tick();
        check_rsp("lock2", 1'b1, 32'd7, 1'b0, 2'd2);
        rsp_ready = 1'b0;
        reset     = 1'b1;
        #1;
        check("midreset.ready", 64'(req_ready), 64'(0));
        tick();
        check("midreset.valid", 64'(rsp_valid), 64'(0));
        check("midreset.ready2", 64'(req_ready), 64'(0));
        reset     = 1'b0;
        req_valid = 4'b1010;
        set_req(1, 32'd10, 32'd20, 1'b1, 1'b0, 1'b0);
        #1;
        check("postreset.ready", 64'(req_ready), 64'(4'b0010));
        tick();
        check_rsp("postreset", 1'b1, 32'd31, 1'b0, 2'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
